// File: rtl/bus_protocol_monitor_pkg.sv
// ---------------------------------------------------------------------------
// bus_protocol_monitor_pkg
// Shared definitions for the valid/ready protocol monitor: error bit indices
// inside the per-channel and per-pair error fields, field widths and the
// channel FSM state encoding.
// ---------------------------------------------------------------------------
package bus_protocol_monitor_pkg;

  // Per-channel error field bit positions.
  localparam int ERR_RESET_VALID   = 0;
  localparam int ERR_VALID_DROP    = 1;
  localparam int ERR_DATA_UNSTABLE = 2;
  localparam int ERR_STALL_TIMEOUT = 3;

  // Per-pair error field bit positions.
  localparam int ERR_OVERFLOW      = 0;
  localparam int ERR_UNDERFLOW     = 1;

  localparam int CH_ERR_W   = 4;
  localparam int PAIR_ERR_W = 2;
  localparam int OUTST_W    = 8;
  localparam int STATE_W    = 2;

  // Channel FSM encoding. POST_RESET is 0 so that a debug view of the state
  // reads all-zero while reset is held.
  typedef enum logic [STATE_W-1:0] {
    POST_RESET = 2'd0,
    IDLE       = 2'd1,
    WAIT       = 2'd2
  } ch_state_e;

endpackage

// File: rtl/bus_channel_monitor.sv
// ---------------------------------------------------------------------------
// bus_channel_monitor
// Observes one valid/ready channel. Holds the channel FSM, the payload
// captured when a stall begins, the stall counter and a saturating transfer
// counter. Error detections are reported combinationally for the current
// clock edge; the parent decides whether they become sticky.
//
// Handshake semantics: a transfer happens at a rising edge where valid and
// ready are both 1. Once valid is raised without ready, the source must keep
// valid high and the payload unchanged until the transfer. Ready may be high
// without valid at any time.
//
// Ports:
//   clock, reset     clock, asynchronous active-high reset
//   valid_i, ready_i channel handshake signals
//   data_i           channel payload
//   state_o          current FSM state (debug view)
//   err_det_o        errors detected at the coming edge (not sticky)
//   hs_o             handshake at the coming edge
//   xfer_count_o     saturating handshake count
// ---------------------------------------------------------------------------
module bus_channel_monitor
  import bus_protocol_monitor_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256,
  parameter int COUNT_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                valid_i,
  input  logic                ready_i,
  input  logic [DATA_W-1:0]   data_i,
  output ch_state_e           state_o,
  output logic [CH_ERR_W-1:0] err_det_o,
  output logic                hs_o,
  output logic [COUNT_W-1:0]  xfer_count_o
);

  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  ch_state_e           state_q, state_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [STALL_W-1:0]  stall_inc;
  logic [COUNT_W-1:0]  xfer_q, xfer_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= POST_RESET;
      cap_q   <= '0;
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      stall_q <= stall_d;
      xfer_q  <= xfer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    stall_d   = stall_q;
    err_det_o = '0;
    stall_inc = stall_q + STALL_ONE;

    case (state_q)
      POST_RESET, IDLE: begin
        // Valid at the very first edge after reset means the source did not
        // honour reset.
        if (state_q == POST_RESET && valid_i) begin
          err_det_o[ERR_RESET_VALID] = 1'b1;
        end
        state_d = IDLE;
        if (valid_i && !ready_i) begin
          state_d = WAIT;
          cap_d   = data_i;
          stall_d = STALL_ONE;
          // The entry edge is the first stalled cycle, so TIMEOUT == 1
          // already expires here.
          err_det_o[ERR_STALL_TIMEOUT] = (STALL_MAX == STALL_ONE);
        end
      end
      WAIT: begin
        if (!valid_i) begin
          err_det_o[ERR_VALID_DROP] = 1'b1;
          state_d = IDLE;
        end else if (ready_i) begin
          state_d = IDLE;
        end else begin
          // Compare against the payload captured on entry, so slow drift
          // across several cycles is still caught.
          if (data_i != cap_q) begin
            err_det_o[ERR_DATA_UNSTABLE] = 1'b1;
          end
          // Counter parks at TIMEOUT, which flags the timeout exactly once.
          if (stall_q != STALL_MAX) begin
            stall_d = stall_inc;
            if (stall_inc == STALL_MAX) begin
              err_det_o[ERR_STALL_TIMEOUT] = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hs_o = valid_i && ready_i;

  always_comb begin
    xfer_d = xfer_q;
    if (hs_o && (xfer_q != {COUNT_W{1'b1}})) begin
      xfer_d = xfer_q + COUNT_W'(1);
    end
  end

  assign state_o      = state_q;
  assign xfer_count_o = xfer_q;

endmodule

// File: rtl/bus_protocol_monitor.sv
// ---------------------------------------------------------------------------
// bus_protocol_monitor
// Passive valid/ready protocol monitor for N_PAIRS request/response channel
// pairs. Channel 2p is the request and 2p+1 the response of pair p. One
// bus_channel_monitor per channel checks handshake rules; this level tracks
// outstanding requests per pair, keeps sticky error flags and produces a
// registered fire pulse.
//
// Ports:
//   clock, reset  clock, asynchronous active-high reset
//   enable        0 suppresses flag setting and fire; state keeps updating
//   clear         synchronous clear of the sticky flags
//   valid, ready  per-channel handshake, one bit per channel
//   data          per-channel payload, channel c at [c*DATA_W +: DATA_W]
//   ch_err        sticky channel errors, channel c at [c*4 +: 4]
//   pair_err      sticky pair errors, pair p at [p*2 +: 2]
//   outstanding   per-pair outstanding count, pair p at [p*8 +: 8]
//   xfer_count    per-channel handshake count, channel c at [c*COUNT_W +: COUNT_W]
//   fire          1 in the cycle after any enabled detection
//   ch_state      channel FSM states (debug), channel c at [c*2 +: 2]
// ---------------------------------------------------------------------------
module bus_protocol_monitor
  import bus_protocol_monitor_pkg::*;
#(
  parameter int N_PAIRS         = 2,
  parameter int DATA_W          = 32,
  parameter int TIMEOUT         = 256,
  parameter int MAX_OUTSTANDING = 1,
  parameter int COUNT_W         = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            clear,
  input  logic [2*N_PAIRS-1:0]            valid,
  input  logic [2*N_PAIRS-1:0]            ready,
  input  logic [2*N_PAIRS*DATA_W-1:0]     data,
  output logic [2*N_PAIRS*CH_ERR_W-1:0]   ch_err,
  output logic [N_PAIRS*PAIR_ERR_W-1:0]   pair_err,
  output logic [N_PAIRS*OUTST_W-1:0]      outstanding,
  output logic [2*N_PAIRS*COUNT_W-1:0]    xfer_count,
  output logic                            fire,
  output logic [2*N_PAIRS*STATE_W-1:0]    ch_state
);

  localparam int N_CH = 2 * N_PAIRS;
  localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(MAX_OUTSTANDING);

  logic [N_CH-1:0][CH_ERR_W-1:0]      ch_det;
  logic [N_CH-1:0]                    hs;
  ch_state_e                          st [N_CH];

  logic [N_PAIRS-1:0][PAIR_ERR_W-1:0] pair_det;
  logic [N_PAIRS-1:0][OUTST_W-1:0]    outst_q, outst_d;

  logic [N_CH*CH_ERR_W-1:0]           ch_err_q, ch_err_d;
  logic [N_PAIRS*PAIR_ERR_W-1:0]      pair_err_q, pair_err_d;
  logic                               fire_q, fire_d;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    bus_channel_monitor #(
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT),
      .COUNT_W (COUNT_W)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .valid_i      (valid[c]),
      .ready_i      (ready[c]),
      .data_i       (data[c*DATA_W +: DATA_W]),
      .state_o      (st[c]),
      .err_det_o    (ch_det[c]),
      .hs_o         (hs[c]),
      .xfer_count_o (xfer_count[c*COUNT_W +: COUNT_W])
    );
    assign ch_state[c*STATE_W +: STATE_W] = st[c];
  end

  // Outstanding tracking. A request and response in the same cycle cancel,
  // even at count 0, since the response may answer the request in flight.
  always_comb begin
    outst_d  = outst_q;
    pair_det = '0;
    for (int p = 0; p < N_PAIRS; p++) begin
      if (hs[2*p] && !hs[2*p+1]) begin
        if (outst_q[p] == OUTST_MAX) begin
          pair_det[p][ERR_OVERFLOW] = 1'b1;
        end else begin
          outst_d[p] = outst_q[p] + OUTST_W'(1);
        end
      end else if (hs[2*p+1] && !hs[2*p]) begin
        if (outst_q[p] == '0) begin
          pair_det[p][ERR_UNDERFLOW] = 1'b1;
        end else begin
          outst_d[p] = outst_q[p] - OUTST_W'(1);
        end
      end
    end
  end

  // Clear is applied before OR-ing in new detections so an error seen in
  // the clearing cycle is not lost.
  always_comb begin
    ch_err_d   = (clear ? '0 : ch_err_q);
    pair_err_d = (clear ? '0 : pair_err_q);
    fire_d     = 1'b0;
    if (enable) begin
      ch_err_d   = ch_err_d | ch_det;
      pair_err_d = pair_err_d | pair_det;
      fire_d     = (|ch_det) || (|pair_det);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outst_q    <= '0;
      ch_err_q   <= '0;
      pair_err_q <= '0;
      fire_q     <= 1'b0;
    end else begin
      outst_q    <= outst_d;
      ch_err_q   <= ch_err_d;
      pair_err_q <= pair_err_d;
      fire_q     <= fire_d;
    end
  end

  assign ch_err      = ch_err_q;
  assign pair_err    = pair_err_q;
  assign outstanding = outst_q;
  assign fire        = fire_q;

endmodule

// File: tb/tb_bus_protocol_monitor.sv
// ---------------------------------------------------------------------------
// tb_bus_protocol_monitor
// Directed bench for bus_protocol_monitor with N_PAIRS=2, TIMEOUT=4,
// MAX_OUTSTANDING=1 and COUNT_W=4 (so counter saturation is reachable).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_bus_protocol_monitor;

  localparam int N_PAIRS = 2;
  localparam int N_CH    = 4;
  localparam int DATA_W  = 32;
  localparam int COUNT_W = 4;

  logic                       clock;
  logic                       reset;
  logic                       enable;
  logic                       clear;
  logic [N_CH-1:0]            valid;
  logic [N_CH-1:0]            ready;
  logic [N_CH*DATA_W-1:0]     data;
  logic [N_CH*4-1:0]          ch_err;
  logic [N_PAIRS*2-1:0]       pair_err;
  logic [N_PAIRS*8-1:0]       outstanding;
  logic [N_CH*COUNT_W-1:0]    xfer_count;
  logic                       fire;
  logic [N_CH*2-1:0]          ch_state;

  int checks = 0;
  int errors = 0;

  bus_protocol_monitor #(
    .N_PAIRS         (N_PAIRS),
    .DATA_W          (DATA_W),
    .TIMEOUT         (4),
    .MAX_OUTSTANDING (1),
    .COUNT_W         (COUNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .valid       (valid),
    .ready       (ready),
    .data        (data),
    .ch_err      (ch_err),
    .pair_err    (pair_err),
    .outstanding (outstanding),
    .xfer_count  (xfer_count),
    .fire        (fire),
    .ch_state    (ch_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver helpers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int c, input logic [DATA_W-1:0] d);
    data[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ch_err"},   32'(ch_err),      32'h0);
    chk({tag, "_pair_err"}, 32'(pair_err),    32'h0);
    chk({tag, "_outst"},    32'(outstanding), 32'h0);
    chk({tag, "_xfer"},     32'(xfer_count),  32'h0);
    chk({tag, "_fire"},     32'(fire),        32'h0);
    chk({tag, "_state"},    32'(ch_state),    32'h0);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    clear  = 1'b0;
    valid  = 4'b0001;
    ready  = 4'b0000;
    data   = '0;
    set_data(0, 32'h0000_1000);
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("in_reset");

    // Release with valid[0] already high: reset-valid error, ch0 stalls.
    reset = 1'b0;
    tick();
    chk("e1_ch_err", 32'(ch_err),   32'h0001);
    chk("e1_fire",   32'(fire),     32'h1);
    chk("e1_state",  32'(ch_state), 32'h56);

    // Payload drifts while stalled.
    set_data(0, 32'h0000_1004);
    tick();
    chk("e2_ch_err", 32'(ch_err), 32'h0005);
    chk("e2_fire",   32'(fire),   32'h1);

    // Ready rises: handshake, request of pair 0 now outstanding.
    ready = 4'b0001;
    tick();
    chk("e3_xfer",   32'(xfer_count),  32'h0001);
    chk("e3_outst",  32'(outstanding), 32'h0001);
    chk("e3_fire",   32'(fire),        32'h0);
    chk("e3_ch_err", 32'(ch_err),      32'h0005);

    // Channel 1 stalls 3 cycles then drops valid.
    valid = 4'b0010;
    ready = 4'b0000;
    repeat (3) tick();
    chk("e6_ch_err", 32'(ch_err), 32'h0005);
    chk("e6_fire",   32'(fire),   32'h0);
    valid = 4'b0000;
    tick();
    chk("e7_ch_err", 32'(ch_err),     32'h0025);
    chk("e7_fire",   32'(fire),       32'h1);
    chk("e7_xfer",   32'(xfer_count), 32'h0001);

    // Channel 2 stall timeout on the 4th stalled edge, flagged once.
    valid = 4'b0100;
    repeat (3) tick();
    chk("e10_ch_err", 32'(ch_err), 32'h0025);
    chk("e10_fire",   32'(fire),   32'h0);
    tick();
    chk("e11_ch_err", 32'(ch_err), 32'h0825);
    chk("e11_fire",   32'(fire),   32'h1);
    tick();
    chk("e12_fire",   32'(fire),   32'h0);
    ready = 4'b0100;
    tick();
    chk("e13_fire",   32'(fire),        32'h0);
    chk("e13_xfer",   32'(xfer_count),  32'h0101);
    chk("e13_outst",  32'(outstanding), 32'h0101);
    chk("e13_ch_err", 32'(ch_err),      32'h0825);

    // Pair 0: second request with one outstanding -> overflow.
    valid = 4'b0001;
    ready = 4'b0001;
    tick();
    chk("e14_outst", 32'(outstanding), 32'h0101);
    chk("e14_perr",  32'(pair_err),    32'h1);
    chk("e14_fire",  32'(fire),        32'h1);
    chk("e14_xfer",  32'(xfer_count),  32'h0102);

    // Response drains, second response underflows.
    valid = 4'b0010;
    ready = 4'b0010;
    tick();
    chk("e15_outst", 32'(outstanding), 32'h0100);
    chk("e15_fire",  32'(fire),        32'h0);
    tick();
    chk("e16_perr",  32'(pair_err),    32'h3);
    chk("e16_fire",  32'(fire),        32'h1);
    chk("e16_outst", 32'(outstanding), 32'h0100);

    // Request and response together at count 0: no error.
    valid = 4'b0011;
    ready = 4'b0011;
    tick();
    chk("e17_perr",  32'(pair_err),    32'h3);
    chk("e17_fire",  32'(fire),        32'h0);
    chk("e17_outst", 32'(outstanding), 32'h0100);
    chk("e17_xfer",  32'(xfer_count),  32'h0133);

    // Clear with a simultaneous pair 1 overflow.
    valid = 4'b0100;
    ready = 4'b0100;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("e18_ch_err", 32'(ch_err),      32'h0000);
    chk("e18_perr",   32'(pair_err),    32'h4);
    chk("e18_fire",   32'(fire),        32'h1);
    chk("e18_outst",  32'(outstanding), 32'h0100);
    chk("e18_xfer",   32'(xfer_count),  32'h0233);

    // Enable low: pair 1 underflow is not flagged, counters still move.
    enable = 1'b0;
    valid  = 4'b1000;
    ready  = 4'b1000;
    tick();
    chk("e19_outst", 32'(outstanding), 32'h0000);
    tick();
    chk("e20_perr",  32'(pair_err),   32'h4);
    chk("e20_fire",  32'(fire),       32'h0);
    chk("e20_xfer",  32'(xfer_count), 32'h2233);

    // Saturate channel 3 transfer counter at 15.
    repeat (13) tick();
    chk("sat_reach", 32'(xfer_count), 32'hF233);
    tick();
    chk("sat_hold",  32'(xfer_count), 32'hF233);

    // Enter WAIT on channel 0, then reset asynchronously mid-stall.
    enable = 1'b1;
    valid  = 4'b0001;
    ready  = 4'b0000;
    set_data(0, 32'h0000_ABCD);
    tick();
    chk("pre_rst_state", 32'(ch_state), 32'h56);
    chk("pre_rst_fire",  32'(fire),     32'h0);
    reset = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_ch_err", 32'(ch_err),     32'h0001);
    chk("post_rst_fire",   32'(fire),       32'h1);
    chk("post_rst_state",  32'(ch_state),   32'h56);
    chk("post_rst_xfer",   32'(xfer_count), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
